// File: rtl/traffic_pkg.sv
// Shared state encoding, lamp constants and digit helper for traffic_ctrl.
package traffic_pkg;

  // Four day phases (codes match the phase output) plus the night flashing state.
  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    EW_G  = 3'd2,
    EW_Y  = 3'd3,
    NIGHT = 3'd4
  } state_e;

  localparam logic [2:0]  LAMP_R      = 3'b100;
  localparam logic [2:0]  LAMP_Y      = 3'b010;
  localparam logic [2:0]  LAMP_G      = 3'b001;
  localparam logic [2:0]  LAMP_OFF    = 3'b000;
  localparam logic [7:0]  DIGIT_BLANK = 8'h0F;
  localparam logic [31:0] DAT_BLANK   = {DIGIT_BLANK, DIGIT_BLANK, DIGIT_BLANK, DIGIT_BLANK};

  // Split a 0..99 value into {tens byte, units byte}; a zero tens digit stays 0.
  function automatic logic [15:0] to_bcd(input logic [6:0] val);
    logic [6:0] tens;
    logic [6:0] units;
    tens  = val / 7'd10;
    units = val % 7'd10;
    return {1'b0, tens, 1'b0, units};
  endfunction

endpackage

// File: rtl/traffic_ctrl_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled, pulses tick_o on the last count.
module tick_gen #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned   CW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: freeze when disabled, restart on clear or after the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = cnt_q;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i & (cnt_q == CNT_MAX);

endmodule

// File: rtl/traffic_ctrl.sv
// Four-phase traffic light sequencer with pedestrian shortening, night flashing
// and a 4-digit countdown word for the seven-segment scanner.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned T_GREEN  = 25,
  parameter int unsigned T_YELLOW = 5,
  parameter int unsigned T_PED    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        night,
  input  logic        ped_req,
  output logic [2:0]  ns_light,
  output logic [2:0]  ew_light,
  output logic [31:0] dat,
  output logic [1:0]  phase
);

  localparam logic [6:0] SEC_G = 7'(T_GREEN);
  localparam logic [6:0] SEC_Y = 7'(T_YELLOW);
  localparam logic [6:0] SEC_P = 7'(T_PED);

  state_e      state_q, state_d;
  logic [6:0]  sec_q, sec_d;
  logic        ped_q, ped_d;
  logic        flash_q, flash_d;
  logic        tick_s, clr_s, show_s;
  logic [6:0]  ns_val_s, ew_val_s;
  logic [2:0]  ns_q, ns_d, ew_q, ew_d;
  logic [31:0] dat_q, dat_d;
  logic [1:0]  phase_q, phase_d;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (en),
    .clr_i  (clr_s),
    .tick_o (tick_s)
  );

  // State register: phase, seconds left, pedestrian latch, night flash level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NS_G;
      sec_q   <= SEC_G;
      ped_q   <= 1'b0;
      flash_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      ped_q   <= ped_d;
      flash_q <= flash_d;
    end
  end

  // Next state: night entry/exit first, then tick countdown, then pedestrian clamp.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    flash_d = flash_q;
    clr_s   = 1'b0;
    ped_d   = (state_q == NIGHT) ? 1'b0 : (ped_q | ped_req);
    if (!en) begin
      state_d = state_q;
    end else if (night && (state_q != NIGHT)) begin
      state_d = NIGHT;
      flash_d = 1'b1;
      clr_s   = 1'b1;
      ped_d   = 1'b0;
    end else if (!night && (state_q == NIGHT)) begin
      state_d = NS_G;
      sec_d   = SEC_G;
      clr_s   = 1'b1;
      ped_d   = 1'b0;
    end else if (state_q == NIGHT) begin
      flash_d = tick_s ? ~flash_q : flash_q;
    end else if (tick_s) begin
      if (sec_q > 7'd1) begin
        sec_d = sec_q - 7'd1;
      end else begin
        // Entering a yellow drops the latch unless a new request lands on this edge.
        case (state_q)
          NS_G:    begin state_d = NS_Y; sec_d = SEC_Y; ped_d = ped_req; end
          NS_Y:    begin state_d = EW_G; sec_d = SEC_G; end
          EW_G:    begin state_d = EW_Y; sec_d = SEC_Y; ped_d = ped_req; end
          EW_Y:    begin state_d = NS_G; sec_d = SEC_G; end
          default: begin state_d = NS_G; sec_d = SEC_G; end
        endcase
      end
    end else if (((state_q == NS_G) || (state_q == EW_G)) && ped_q && (sec_q > SEC_P)) begin
      sec_d = SEC_P;
    end else begin
      sec_d = sec_q;
    end
  end

  // Output decode: lamps, phase code and time-to-next-change per direction.
  always_comb begin
    ns_d     = LAMP_R;
    ew_d     = LAMP_R;
    phase_d  = 2'b00;
    ns_val_s = sec_q;
    ew_val_s = sec_q;
    show_s   = 1'b1;
    case (state_q)
      NS_G:  begin ns_d = LAMP_G; phase_d = 2'b00; ew_val_s = sec_q + SEC_Y; end
      NS_Y:  begin ns_d = LAMP_Y; phase_d = 2'b01; end
      EW_G:  begin ew_d = LAMP_G; phase_d = 2'b10; ns_val_s = sec_q + SEC_Y; end
      EW_Y:  begin ew_d = LAMP_Y; phase_d = 2'b11; end
      NIGHT: begin
        ns_d   = flash_q ? LAMP_Y : LAMP_OFF;
        ew_d   = flash_q ? LAMP_Y : LAMP_OFF;
        show_s = 1'b0;
      end
      default: begin ns_d = LAMP_R; ew_d = LAMP_R; show_s = 1'b0; end
    endcase
    if (show_s) begin
      dat_d = {to_bcd(ns_val_s), to_bcd(ew_val_s)};
    end else begin
      dat_d = DAT_BLANK;
    end
  end

  // Output register: one cycle behind the state, frozen while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      ns_q    <= LAMP_R;
      ew_q    <= LAMP_R;
      dat_q   <= DAT_BLANK;
      phase_q <= 2'b00;
    end else if (en) begin
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      dat_q   <= dat_d;
      phase_q <= phase_d;
    end else begin
      ns_q    <= ns_q;
      ew_q    <= ew_q;
      dat_q   <= dat_q;
      phase_q <= phase_q;
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign dat      = dat_q;
  assign phase    = phase_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Bench for traffic_ctrl: vector table, hand-written corner sequences and
// random stimulus against a remaining-cycles reference model.
module tb_traffic_ctrl;

  localparam int HZ = 10;
  localparam int TG = 3;
  localparam int TY = 2;
  localparam int TP = 1;
  localparam int NT = 14;

  typedef struct {
    int          cyc;
    logic        en;
    logic        night;
    logic [2:0]  ns;
    logic [2:0]  ew;
    logic [31:0] dat;
    logic [1:0]  ph;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, en, night, ped_req;
  logic [2:0]  ns_light, ew_light;
  logic [31:0] dat;
  logic [1:0]  phase;
  logic        p_rst, p_ped;
  logic [2:0]  p_ns, p_ew;
  logic [31:0] p_dat;
  logic [1:0]  p_phase;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl [NT];

  // Reference model: time left in the phase counted in cycles.
  bit          m_night = 1'b0;
  bit          m_ped   = 1'b0;
  int          m_phase = 0;
  int          m_rem   = TG * HZ;
  int          m_n     = 0;
  logic [2:0]  e_ns    = 3'b100;
  logic [2:0]  e_ew    = 3'b100;
  logic [31:0] e_dat   = 32'h0F0F0F0F;
  logic [1:0]  e_ph    = 2'b00;
  bit          e_night = 1'b0;

  always #5 clk = ~clk;

  traffic_ctrl #(.CLK_HZ(HZ), .T_GREEN(TG), .T_YELLOW(TY), .T_PED(TP)) dut (
    .clk(clk), .rst(rst), .en(en), .night(night), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .dat(dat), .phase(phase)
  );

  traffic_ctrl #(.CLK_HZ(4), .T_GREEN(25), .T_YELLOW(5), .T_PED(5)) dut_p (
    .clk(clk), .rst(p_rst), .en(1'b1), .night(1'b0), .ped_req(p_ped),
    .ns_light(p_ns), .ew_light(p_ew), .dat(p_dat), .phase(p_phase)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_out();
    int s, nv, ev;
    bit on;
    if (m_night) begin
      on      = ((m_n / HZ) % 2) == 0;
      e_ns    = on ? 3'b010 : 3'b000;
      e_ew    = e_ns;
      e_dat   = 32'h0F0F0F0F;
      e_ph    = 2'b00;
      e_night = 1'b1;
    end else begin
      s       = (m_rem + HZ - 1) / HZ;
      nv      = s + ((m_phase == 2) ? TY : 0);
      ev      = s + ((m_phase == 0) ? TY : 0);
      e_ns    = (m_phase == 0) ? 3'b001 : (m_phase == 1) ? 3'b010 : 3'b100;
      e_ew    = (m_phase == 2) ? 3'b001 : (m_phase == 3) ? 3'b010 : 3'b100;
      e_dat   = {8'(nv / 10), 8'(nv % 10), 8'(ev / 10), 8'(ev % 10)};
      e_ph    = 2'(m_phase);
      e_night = 1'b0;
    end
  endtask

  task automatic model_edge();
    int s, f;
    bit newped;
    if (rst) begin
      e_ns = 3'b100; e_ew = 3'b100; e_dat = 32'h0F0F0F0F; e_ph = 2'b00; e_night = 1'b0;
      m_night = 1'b0; m_phase = 0; m_rem = TG * HZ; m_ped = 1'b0; m_n = 0;
    end else if (!en) begin
      if (!m_night) m_ped = m_ped | ped_req;
    end else begin
      model_out();
      if (night && !m_night) begin
        m_night = 1'b1; m_n = 0; m_ped = 1'b0;
      end else if (!night && m_night) begin
        m_night = 1'b0; m_phase = 0; m_rem = TG * HZ; m_ped = 1'b0;
      end else if (m_night) begin
        m_n++;
      end else begin
        s      = (m_rem + HZ - 1) / HZ;
        f      = m_rem - (s - 1) * HZ;
        newped = m_ped | ped_req;
        if (m_rem == 1) begin
          m_phase = (m_phase + 1) % 4;
          m_rem   = ((m_phase % 2 == 0) ? TG : TY) * HZ;
          if (m_phase % 2 == 1) newped = ped_req;
        end else if (f != 1 && m_phase % 2 == 0 && m_ped && s > TP) begin
          m_rem = (TP - 1) * HZ + f - 1;
        end else begin
          m_rem--;
        end
        m_ped = newped;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check("model", 64'({ns_light, ew_light, dat, phase}), 64'({e_ns, e_ew, e_dat, e_ph}));
    if (!e_night) check("one_red", 64'((ns_light == 3'b100) || (ew_light == 3'b100)), 64'd1);
  endtask

  task automatic wait_ph(input logic [1:0] p);
    int g;
    g = 0;
    while (phase != p && g < 400) begin
      step();
      g++;
    end
    check("wait_phase", 64'(phase), 64'(p));
  endtask

  initial begin
    int cyc, dur, g;
    logic [2:0] y;
    rst = 1'b1; en = 1'b1; night = 1'b0; ped_req = 1'b0;
    p_rst = 1'b1; p_ped = 1'b0;

    tbl[0]  = '{1,   1'b1, 1'b0, 3'b001, 3'b100, 32'h00030005, 2'b00};
    tbl[1]  = '{10,  1'b1, 1'b0, 3'b001, 3'b100, 32'h00030005, 2'b00};
    tbl[2]  = '{11,  1'b1, 1'b0, 3'b001, 3'b100, 32'h00020004, 2'b00};
    tbl[3]  = '{30,  1'b1, 1'b0, 3'b001, 3'b100, 32'h00010003, 2'b00};
    tbl[4]  = '{31,  1'b1, 1'b0, 3'b010, 3'b100, 32'h00020002, 2'b01};
    tbl[5]  = '{41,  1'b1, 1'b0, 3'b010, 3'b100, 32'h00010001, 2'b01};
    tbl[6]  = '{50,  1'b1, 1'b0, 3'b010, 3'b100, 32'h00010001, 2'b01};
    tbl[7]  = '{51,  1'b1, 1'b0, 3'b100, 3'b001, 32'h00050003, 2'b10};
    tbl[8]  = '{61,  1'b1, 1'b0, 3'b100, 3'b001, 32'h00040002, 2'b10};
    tbl[9]  = '{80,  1'b1, 1'b0, 3'b100, 3'b001, 32'h00030001, 2'b10};
    tbl[10] = '{81,  1'b1, 1'b0, 3'b100, 3'b010, 32'h00020002, 2'b11};
    tbl[11] = '{91,  1'b1, 1'b0, 3'b100, 3'b010, 32'h00010001, 2'b11};
    tbl[12] = '{100, 1'b1, 1'b0, 3'b100, 3'b010, 32'h00010001, 2'b11};
    tbl[13] = '{101, 1'b1, 1'b0, 3'b001, 3'b100, 32'h00030005, 2'b00};

    repeat (2) step();
    check("reset", 64'({ns_light, ew_light, dat, phase}), 64'({3'b100, 3'b100, 32'h0F0F0F0F, 2'b00}));
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < NT; i++) begin
      en = tbl[i].en;
      night = tbl[i].night;
      while (cyc < tbl[i].cyc) begin
        step();
        cyc++;
      end
      check($sformatf("tbl%0d", i), 64'({ns_light, ew_light, dat, phase}),
            64'({tbl[i].ns, tbl[i].ew, tbl[i].dat, tbl[i].ph}));
    end

    // en low for 37 cycles in the middle of NS_Y stretches it to 57 cycles.
    wait_ph(2'b01);
    dur = 1;
    repeat (4) begin step(); dur++; end
    en = 1'b0;
    repeat (37) begin step(); dur++; end
    check("en_freeze", 64'({ns_light, ew_light, dat, phase}), 64'({3'b010, 3'b100, 32'h00020002, 2'b01}));
    en = 1'b1;
    g = 0;
    do begin
      step();
      g++;
      if (phase == 2'b01) dur++;
    end while (phase == 2'b01 && g < 100);
    check("ns_y_len", 64'(dur), 64'd57);

    // Night mode entered mid EW_G: 10 cycles yellow, 10 cycles dark, repeating.
    wait_ph(2'b10);
    repeat (3) step();
    night = 1'b1;
    step();
    for (int i = 0; i < 40; i++) begin
      step();
      y = (((i / 10) % 2) == 0) ? 3'b010 : 3'b000;
      check("night", 64'({ns_light, ew_light, dat, phase}), 64'({y, y, 32'h0F0F0F0F, 2'b00}));
    end
    night = 1'b0;
    repeat (2) step();
    check("night_exit", 64'({ns_light, ew_light, dat, phase}), 64'({3'b001, 3'b100, 32'h00030005, 2'b00}));

    // One-cycle reset during EW_Y.
    wait_ph(2'b11);
    repeat (5) step();
    rst = 1'b1;
    step();
    check("mid_reset", 64'({ns_light, ew_light, dat, phase}), 64'({3'b100, 3'b100, 32'h0F0F0F0F, 2'b00}));
    rst = 1'b0;
    step();
    check("restart", 64'({ns_light, ew_light, dat, phase}), 64'({3'b001, 3'b100, 32'h00030005, 2'b00}));

    // Pedestrian requests on the 4-cycle, T_GREEN=25 instance.
    step();
    p_rst = 1'b0;
    for (int k = 1; k <= 62; k++) begin
      p_ped = (k == 21) || (k == 45);
      step();
      if (k == 22) check("ped_before", 64'(p_dat[31:16]), 64'h0200);
      if (k == 23) check("ped_clamp", 64'({p_ns, p_ew, p_dat, p_phase}), 64'({3'b001, 3'b100, 32'h00050100, 2'b00}));
      if (k == 40) check("ped_last_g", 64'({p_dat, p_phase}), 64'({32'h00010006, 2'b00}));
      if (k == 41) check("ped_yellow", 64'({p_ns, p_ew, p_dat, p_phase}), 64'({3'b010, 3'b100, 32'h00050005, 2'b01}));
      if (k == 60) check("ped_ns_y_full", 64'({p_dat, p_phase}), 64'({32'h00010001, 2'b01}));
      if (k == 61) check("ped_ew_entry", 64'({p_ns, p_ew, p_dat, p_phase}), 64'({3'b100, 3'b001, 32'h03000205, 2'b10}));
      if (k == 62) check("ped_ew_clamp", 64'({p_dat, p_phase}), 64'({32'h01000005, 2'b10}));
    end
    p_ped = 1'b0;

    // Random stimulus against the reference model.
    for (int c = 0; c < 3000; c++) begin
      en      = ($urandom_range(9) != 0);
      ped_req = ($urandom_range(19) == 0);
      if ($urandom_range(149) == 0) night = ~night;
      rst     = ($urandom_range(499) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
